// File: rtl/mem_arbiter_if.sv
// Bus bundle between three requesting masters, the arbiter and one memory slave.
// Signal names are seen from the arbiter: *_i are arbiter inputs and *_o are
// arbiter outputs.
//   mN_req_i/we_i/addr_i/wdata_i : master N request and its payload
//   mN_gnt_o/rvalid_o/rdata_o    : master N grant pulse, completion pulse, read data
//   s_req_o/we_o/addr_o/wdata_o  : registered request to the slave
//   s_ack_i/s_rdata_i            : slave completion pulse and read data
// Modport slave is the arbiter's view. Modport master is the view of the
// environment that drives requests and models the slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req_i, m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_gnt_o, m0_rvalid_o;
  logic [DATA_W-1:0] m0_rdata_o;

  logic              m1_req_i, m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_gnt_o, m1_rvalid_o;
  logic [DATA_W-1:0] m1_rdata_o;

  logic              m2_req_i, m2_we_i;
  logic [ADDR_W-1:0] m2_addr_i;
  logic [DATA_W-1:0] m2_wdata_i;
  logic              m2_gnt_o, m2_rvalid_o;
  logic [DATA_W-1:0] m2_rdata_o;

  logic              s_req_o, s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_wdata_o;
  logic              s_ack_i;
  logic [DATA_W-1:0] s_rdata_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  m2_req_i, m2_we_i, m2_addr_i, m2_wdata_i,
    output m2_gnt_o, m2_rvalid_o, m2_rdata_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o,
    input  s_ack_i, s_rdata_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output m2_req_i, m2_we_i, m2_addr_i, m2_wdata_i,
    input  m2_gnt_o, m2_rvalid_o, m2_rdata_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
    output s_ack_i, s_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory slave among three masters (m0 load/store,
// m1 instruction fetch, m2 debug). One transaction is in flight at a time.
// Fixed priority m0 > m1 > m2, except that m1/m2 become urgent after losing
// MAX_WAIT arbitrations in a row. A BUSY access without s_ack_i is aborted
// after TIMEOUT cycles (0 disables the timeout).
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active high
//   bus         : mem_arbiter_if.slave (master requests and slave bus)
//   err_o       : one-cycle pulse on timeout abort, together with owner's rvalid
//   hold_flag_o : m1 request pending and not completing this cycle
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          err_o,
  output logic          hold_flag_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TMO_EN   = (TIMEOUT != 0);

  logic [0:0]        r_state;
  logic [1:0]        r_owner;
  logic [WW-1:0]     r_wait [1:2];
  logic [TW-1:0]     r_tmo;
  logic              r_s_req, r_s_we;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wdata;

  logic [2:0]        w_req;
  logic              w_any, w_urg1, w_urg2;
  logic [1:0]        w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_idle, w_busy, w_tmo_hit, w_ack, w_abort, w_done;
  logic [2:0]        w_gnt, w_rvalid;
  logic [DATA_W-1:0] w_rdata;

  assign w_req  = {bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};
  assign w_any  = |w_req;
  assign w_idle = (r_state == ST_IDLE);
  assign w_busy = (r_state == ST_BUSY);

  // m0 never starves, so only m1/m2 can be promoted to urgent.
  assign w_urg1 = w_req[1] && (r_wait[1] == WAIT_MAX);
  assign w_urg2 = w_req[2] && (r_wait[2] == WAIT_MAX);

  always_comb begin
    w_win = 2'd0;
    if (w_urg1)        w_win = 2'd1;
    else if (w_urg2)   w_win = 2'd2;
    else if (w_req[0]) w_win = 2'd0;
    else if (w_req[1]) w_win = 2'd1;
    else if (w_req[2]) w_win = 2'd2;
  end

  always_comb begin
    w_sel_we    = bus.m0_we_i;
    w_sel_addr  = bus.m0_addr_i;
    w_sel_wdata = bus.m0_wdata_i;
    case (w_win)
      2'd1: begin
        w_sel_we    = bus.m1_we_i;
        w_sel_addr  = bus.m1_addr_i;
        w_sel_wdata = bus.m1_wdata_i;
      end
      2'd2: begin
        w_sel_we    = bus.m2_we_i;
        w_sel_addr  = bus.m2_addr_i;
        w_sel_wdata = bus.m2_wdata_i;
      end
      default: ;
    endcase
  end

  // An ack arriving in the timeout cycle takes precedence over the abort.
  assign w_tmo_hit = TMO_EN && (r_tmo == TMO_LAST);
  assign w_ack     = w_busy && bus.s_ack_i;
  assign w_abort   = w_busy && !bus.s_ack_i && w_tmo_hit;
  assign w_done    = w_ack || w_abort;
  assign w_rdata   = w_ack ? bus.s_rdata_i : '0;

  always_comb begin
    w_gnt    = '0;
    w_rvalid = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_gnt[i]    = w_idle && w_any && (w_win == 2'(i));
      w_rvalid[i] = w_done && (r_owner == 2'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_tmo     <= '0;
      r_s_req   <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner   <= w_win;
            r_s_we    <= w_sel_we;
            r_s_addr  <= w_sel_addr;
            r_s_wdata <= w_sel_wdata;
            r_s_req   <= 1'b1;
            r_tmo     <= '0;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_done) begin
            r_s_req <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Lost-arbitration counters: count only IDLE cycles in which the master
  // requested and someone else won; any cycle with req low clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait[1] <= '0;
      r_wait[2] <= '0;
    end else begin
      for (int unsigned i = 1; i < 3; i++) begin
        if (!w_req[i]) begin
          r_wait[i] <= '0;
        end else if (w_idle) begin
          if (w_win == 2'(i))            r_wait[i] <= '0;
          else if (r_wait[i] != WAIT_MAX) r_wait[i] <= r_wait[i] + 1'b1;
        end
      end
    end
  end

  assign bus.m0_gnt_o    = w_gnt[0];
  assign bus.m1_gnt_o    = w_gnt[1];
  assign bus.m2_gnt_o    = w_gnt[2];
  assign bus.m0_rvalid_o = w_rvalid[0];
  assign bus.m1_rvalid_o = w_rvalid[1];
  assign bus.m2_rvalid_o = w_rvalid[2];
  assign bus.m0_rdata_o  = w_rvalid[0] ? w_rdata : '0;
  assign bus.m1_rdata_o  = w_rvalid[1] ? w_rdata : '0;
  assign bus.m2_rdata_o  = w_rvalid[2] ? w_rdata : '0;

  assign bus.s_req_o   = r_s_req;
  assign bus.s_we_o    = r_s_we;
  assign bus.s_addr_o  = r_s_addr;
  assign bus.s_wdata_o = r_s_wdata;

  assign err_o       = w_abort;
  assign hold_flag_o = bus.m1_req_i && !w_rvalid[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter. Stimulus drives three masters
// and a slave model; a reference model predicts grants and completions into
// queues; a monitor pops and compares whenever the DUT shows gnt/rvalid.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic err, hold;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_o(err), .hold_flag_o(hold)
  );

  logic          req [3];
  logic          we  [3];
  logic [AW-1:0] addr [3];
  logic [DW-1:0] wdata [3];
  logic          s_ack;
  logic [DW-1:0] s_rdata;

  assign bus.m0_req_i = req[0]; assign bus.m0_we_i = we[0];
  assign bus.m0_addr_i = addr[0]; assign bus.m0_wdata_i = wdata[0];
  assign bus.m1_req_i = req[1]; assign bus.m1_we_i = we[1];
  assign bus.m1_addr_i = addr[1]; assign bus.m1_wdata_i = wdata[1];
  assign bus.m2_req_i = req[2]; assign bus.m2_we_i = we[2];
  assign bus.m2_addr_i = addr[2]; assign bus.m2_wdata_i = wdata[2];
  assign bus.s_ack_i = s_ack;
  assign bus.s_rdata_i = s_rdata;

  logic [2:0]    gnt, rv;
  logic [DW-1:0] rd [3];
  assign gnt = {bus.m2_gnt_o, bus.m1_gnt_o, bus.m0_gnt_o};
  assign rv  = {bus.m2_rvalid_o, bus.m1_rvalid_o, bus.m0_rvalid_o};
  assign rd[0] = bus.m0_rdata_o;
  assign rd[1] = bus.m1_rdata_o;
  assign rd[2] = bus.m2_rdata_o;

  typedef struct { int m; logic we; logic [AW-1:0] a; logic [DW-1:0] d; } gnt_t;
  typedef struct { int m; logic [DW-1:0] rd; logic e; } cpl_t;
  gnt_t qg[$];
  cpl_t qc[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (evaluated once per cycle) ----------------
  bit   model_en = 0, mon_en = 0;
  bit   busy;
  int   owner, bcyc, w;
  int   wcnt [3];
  bit   granted [3], done [3], outst [3];
  gnt_t ge;
  cpl_t ce;

  always @(negedge clk) begin
    if (model_en && !rst) begin
      if (!busy) begin
        w = -1;
        for (int i = 1; i < 3; i++) if (w < 0 && req[i] && wcnt[i] == MW) w = i;
        for (int i = 0; i < 3; i++) if (w < 0 && req[i]) w = i;
        for (int i = 1; i < 3; i++)
          wcnt[i] = (!req[i] || i == w) ? 0 : ((wcnt[i] < MW) ? wcnt[i] + 1 : MW);
        if (w >= 0) begin
          ge = '{m: w, we: we[w], a: addr[w], d: wdata[w]};
          qg.push_back(ge);
          busy = 1; owner = w; bcyc = 0; granted[w] = 1;
        end
      end else begin
        for (int i = 1; i < 3; i++) if (!req[i]) wcnt[i] = 0;
        if (s_ack) begin
          ce = '{m: owner, rd: s_rdata, e: 1'b0};
          qc.push_back(ce); busy = 0; done[owner] = 1;
        end else if (bcyc == TO - 1) begin
          ce = '{m: owner, rd: '0, e: 1'b1};
          qc.push_back(ce); busy = 0; done[owner] = 1;
        end else begin
          bcyc++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit          sb_pend = 0;
  gnt_t        sb_exp;
  logic [2:0]  exp_g, exp_rv;
  logic        exp_hold;

  always @(negedge clk) begin
    #1;
    if (mon_en && !rst) begin
      if (sb_pend) begin
        sb_pend = 0;
        chk("s_req_o", bus.s_req_o, 1'b1);
        chk("s_we_o", bus.s_we_o, sb_exp.we);
        chk("s_addr_o", bus.s_addr_o, sb_exp.a);
        chk("s_wdata_o", bus.s_wdata_o, sb_exp.d);
      end
      exp_g = (qg.size() > 0) ? 3'(1 << qg[0].m) : 3'b000;
      chk("gnt", gnt, exp_g);
      if (qg.size() > 0) begin
        sb_exp = qg.pop_front();
        sb_pend = 1;
      end
      exp_rv   = (qc.size() > 0) ? 3'(1 << qc[0].m) : 3'b000;
      exp_hold = req[1] && !(qc.size() > 0 && qc[0].m == 1);
      chk("hold_flag", hold, exp_hold);
      chk("rvalid", rv, exp_rv);
      if (qc.size() > 0) begin
        ce = qc.pop_front();
        chk("rdata", rd[ce.m], ce.rd);
        chk("err_o", err, ce.e);
        for (int i = 0; i < 3; i++) if (i != ce.m) chk("rdata_idle", rd[i], '0);
      end else begin
        chk("err_idle", err, 1'b0);
        for (int i = 0; i < 3; i++) chk("rdata_idle", rd[i], '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  int ack_at = 0;
  int force_plan = -1;
  int rate [3] = '{60, 30, 30};

  function automatic int pick_plan();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 3);
    if (r < 8) return TO - 1;   // ack lands exactly in the timeout cycle
    return 1000;                // never ack
  endfunction

  task automatic drive_cycle(input bit allow_new);
    for (int m = 0; m < 3; m++) begin
      if (done[m]) begin done[m] = 0; outst[m] = 0; req[m] = 1'b0; end
      if (granted[m]) begin
        granted[m] = 0; outst[m] = 1;
        ack_at = (force_plan >= 0) ? force_plan : pick_plan();
      end
      if (req[m] && outst[m] && $urandom_range(0, 99) < 2) begin
        req[m] = 1'b0;  // drop while in flight; access must still complete
      end else if (allow_new && !req[m] && !outst[m] && $urandom_range(0, 99) < rate[m]) begin
        req[m] = 1'b1; we[m] = 1'($urandom_range(0, 1));
        addr[m] = $urandom; wdata[m] = $urandom;
      end
    end
    s_rdata = $urandom;
    s_ack = busy ? (bcyc == ack_at) : ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    rst = 1'b1; s_ack = 1'b0; s_rdata = '0;
    for (int m = 0; m < 3; m++) begin
      req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
    end
    #1;
    chk("rst_s_req", bus.s_req_o, 1'b0);
    chk("rst_s_we", bus.s_we_o, 1'b0);
    chk("rst_s_addr", bus.s_addr_o, '0);
    chk("rst_s_wdata", bus.s_wdata_o, '0);
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rvalid", rv, 3'b000);
    chk("rst_err", err, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; model_en = 1; mon_en = 1;

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1; drive_cycle(1);
    end
    for (int c = 0; c < 200; c++) begin
      if (!busy && !outst[0] && !outst[1] && !outst[2] && !req[0] && !req[1] && !req[2]) break;
      @(posedge clk); #1; drive_cycle(0);
    end
    chk("drain_idle", {busy, outst[0], outst[1], outst[2], req[0], req[1], req[2]}, '0);

    // Reset in the middle of a BUSY access from m2.
    force_plan = 1000;
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0000_0300; wdata[2] = '0;
    for (int c = 0; c < 10 && !busy; c++) begin
      @(posedge clk); #1; drive_cycle(0);
    end
    chk("mid_busy_reached", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_s_req", bus.s_req_o, 1'b0);
    chk("midrst_s_addr", bus.s_addr_o, '0);
    chk("midrst_rvalid", rv, 3'b000);
    chk("midrst_err", err, 1'b0);
    busy = 0; sb_pend = 0; qg.delete(); qc.delete(); s_ack = 1'b0;
    for (int m = 0; m < 3; m++) begin
      wcnt[m] = 0; granted[m] = 0; done[m] = 0; outst[m] = 0; req[m] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    force_plan = 0;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0200; wdata[0] = 32'h1234_5678;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; drive_cycle(0);
      if (!req[0] && !outst[0] && !busy) break;
    end
    chk("post_reset_done", {req[0], outst[0], busy}, 3'b000);
    repeat (3) @(posedge clk);
    #2;
    chk("queues_empty", qg.size() + qc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
